ex_mem_loader: RTL and testbench
================================

# ex_mem_loader

Byte-stream program loader that sits directly upstream of the `riscv` core's external-memory load port. It parses a framed byte stream (LOAD / RUN commands), packs the payload into 32-bit word pairs, and drives one `enable_load_ex_mem` write pulse per address. Each write updates the instruction and data memories at the same address. It also owns the core's reset, holding the core in reset while memories are being written and releasing it on RUN.

## Interface
Parameters:
- `ADDR_W`, default 9: width of the external memory addresses; wraps at 2^ADDR_W − 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader accepts `in_data`. A byte transfers when valid && ready.
- `core_reset`  out  1  drives `riscv.reset`.
- `enable_load_ex_mem`  out  1  one-cycle write strobe to the core.
- `InstExMemAddress`, `DataExMemAddress`  out  ADDR_W  write address; both always carry the same value.
- `InstExMemData1`, `InstExMemData2`, `DataExMemData1`, `DataExMemData2`  out  32  write data.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky error flag; cleared only by `reset`.

## Operation
Frame format:
- LOAD = 0xA5, ADDR_HI, ADDR_LO, COUNT, then COUNT × 16 payload bytes.
  - Start address = {ADDR_HI, ADDR_LO}[ADDR_W-1:0]; upper bits are ignored.
  - COUNT = 0 means 256 entries.
  - Payload per entry, in order: InstData1, InstData2, DataData1, DataData2. Each word is little-endian (first byte → bits 7:0).
- RUN = 0x3C, no operands.
- Any other command byte in IDLE: byte consumed, `err` set, state stays IDLE.

States and transitions:
- IDLE → ADDR_HI on LOAD; `core_reset` rises in the cycle after the LOAD byte is accepted.
- ADDR_HI → ADDR_LO → COUNT → PAYLOAD.
- PAYLOAD: a 4-bit byte counter fills the 128-bit pack register. After the 16th byte → WRITE.
- WRITE (one cycle):
  - `enable_load_ex_mem` = 1; address and data outputs stable.
  - Then the address increments, wrapping from 2^ADDR_W − 1 to 0, and the remaining count decrements.
  - Count remaining → PAYLOAD; count exhausted → IDLE (or CSUM when the checksum feature is compiled in).
- RUN accepted in IDLE: `core_reset` falls in the next cycle.
- LOAD after RUN: `core_reset` reasserts. The core never runs while memories are being written.

Outputs:
- Address and data outputs hold their last written values between WRITE pulses.
- Reset values: `in_ready`=0 (during reset), `core_reset`=1, `enable_load_ex_mem`=0, all address and data outputs 0, `busy`=0, `err`=0.
- Reset mid-frame: returns to IDLE immediately; the partial entry is discarded; no write strobe.

## Timing
- `in_ready` = 1 in IDLE, ADDR_HI, ADDR_LO, COUNT, PAYLOAD and CSUM; 0 in WRITE.
- Throughput: 17 cycles per entry at full input rate (16 byte cycles + 1 WRITE cycle).
- Write latency: the `enable_load_ex_mem` pulse occurs in the cycle immediately after the 16th payload byte handshake.
- The input side may stall `in_valid` arbitrarily. The loader does not advance without a handshake and has no timeout.
- Output address and data change only on the clock edge that enters WRITE. They are registered, with no combinational path from `in_data`.

## Configuration
Macro `EX_MEM_LOADER_CHECKSUM_EN`:
- Defined:
  - A LOAD frame ends with one extra CSUM byte.
  - The expected value is the XOR of all bytes from ADDR_HI through the last payload byte.
  - On mismatch, `err` is set. Writes already issued are not undone.
  - CSUM → IDLE.
- Undefined: no CSUM state or byte; COUNT exhaustion → IDLE directly.

## Structure
- Shared package `ex_mem_pkg`:
  - command constants `CMD_LOAD`, `CMD_RUN`;
  - state enum `ldr_state_t`;
  - `EX_MEM_AW` = 9, used as the default for `ADDR_W`.
- Sub-module `ex_mem_word_pack`:
  - 16-byte little-endian shift/pack register with a byte counter and a `full` flag;
  - emits the four 32-bit words.
- The top level holds the FSM, address counter, entry counter, `core_reset` register and checksum logic.

## Test plan
- After reset: `core_reset`=1, `busy`=0, `enable_load_ex_mem`=0, all address and data outputs 0.
- LOAD 0xA5,00,00,01 with payload words 0x00100393, 0x00038303, 0x00008F00, 0x000000FF, followed by RUN:
  - exactly one `enable_load_ex_mem` pulse, address 0, with `InstExMemData1`=0x00100393, `InstExMemData2`=0x00038303, `DataExMemData1`=0x00008F00, `DataExMemData2`=0x000000FF;
  - `core_reset` falls one cycle after RUN is accepted.
- LOAD with address 0x01FF and COUNT 2: two pulses, at addresses 511 then 0.
- `in_valid` toggled randomly during the payload: data unchanged versus the full-rate run, and `in_ready`=0 exactly during WRITE cycles.
- Command byte 0x77, then a valid LOAD: `err`=1, the LOAD still completes normally, and `err` stays 1 until reset.
- `reset` asserted after 9 payload bytes: no pulse, state IDLE. With `EX_MEM_LOADER_CHECKSUM_EN` defined, a corrupted CSUM byte sets `err`.

Source files
------------

// File: rtl/ex_mem_loader_pkg.sv
// Shared constants and state encoding for the external-memory program loader.
package ex_mem_pkg;

    localparam int         EX_MEM_AW = 9;
    localparam logic [7:0] CMD_LOAD  = 8'hA5;
    localparam logic [7:0] CMD_RUN   = 8'h3C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_COUNT,
        S_PAYLOAD,
        S_WRITE,
        S_CSUM
    } ldr_state_t;

endpackage

// File: rtl/ex_mem_loader_if.sv
// Byte-stream input channel of the loader: one byte moves when in_valid && in_ready.
interface ex_mem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/ex_mem_word_pack.sv
// 16-byte little-endian pack register: byte n of an entry lands in bits 8n+7:8n.
// Words come from the next-state value so the entry is complete on the edge accepting byte 16.
module ex_mem_word_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        full_o,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o
);

    logic [127:0] sr_q;
    logic [127:0] sr_d;
    logic [3:0]   cnt_q;

    assign sr_d    = byte_vld_i ? {byte_dat_i, sr_q[127:8]} : sr_q;
    assign full_o  = byte_vld_i && (cnt_q == 4'hF);
    assign inst1_o = sr_d[31:0];
    assign inst2_o = sr_d[63:32];
    assign data1_o = sr_d[95:64];
    assign data2_o = sr_d[127:96];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q <= sr_d;
            if (clr_i)
                cnt_q <= '0;
            else if (byte_vld_i)
                cnt_q <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/ex_mem_loader.sv
// Framed LOAD/RUN byte-stream loader driving the core's external-memory write port and reset.
// Optional trailing checksum byte on LOAD frames when EX_MEM_LOADER_CHECKSUM_EN is defined.
module ex_mem_loader
    import ex_mem_pkg::*;
#(
    parameter int ADDR_W = EX_MEM_AW
) (
    input  logic              clk,
    input  logic              reset,
    ex_mem_loader_if.slave    in_if,
    output logic              core_reset,
    output logic              enable_load_ex_mem,
    output logic [ADDR_W-1:0] InstExMemAddress,
    output logic [ADDR_W-1:0] DataExMemAddress,
    output logic [31:0]       InstExMemData1,
    output logic [31:0]       InstExMemData2,
    output logic [31:0]       DataExMemData1,
    output logic [31:0]       DataExMemData2,
    output logic              busy,
    output logic              err
);

    ldr_state_t        state_q, state_d;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] addr_q, addr_out_q;
    logic [8:0]        cnt_q;
    logic              core_reset_q, en_q, busy_q, err_q;
    logic [31:0]       i1_q, i2_q, d1_q, d2_q;
    logic              fire, pack_full;
    logic [31:0]       w_i1, w_i2, w_d1, w_d2;
    logic [15:0]       addr16;
`ifdef EX_MEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign in_if.in_ready = !reset && (state_q != S_WRITE);
    assign fire           = in_if.in_valid && in_if.in_ready;
    assign addr16         = {hi_q, in_if.in_data};

    ex_mem_word_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_q == S_IDLE),
        .byte_vld_i (fire && (state_q == S_PAYLOAD)),
        .byte_dat_i (in_if.in_data),
        .full_o     (pack_full),
        .inst1_o    (w_i1),
        .inst2_o    (w_i2),
        .data1_o    (w_d1),
        .data2_o    (w_d2)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (fire && in_if.in_data == CMD_LOAD) state_d = S_ADDR_HI;
            S_ADDR_HI: if (fire) state_d = S_ADDR_LO;
            S_ADDR_LO: if (fire) state_d = S_COUNT;
            S_COUNT:   if (fire) state_d = S_PAYLOAD;
            S_PAYLOAD: if (pack_full) state_d = S_WRITE;
            S_WRITE: begin
                if (cnt_q != 9'd1)
                    state_d = S_PAYLOAD;
                else
`ifdef EX_MEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
            end
            S_CSUM: begin
                if (fire) state_d = S_IDLE;
`else
                    state_d = S_IDLE;
`endif
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            addr_q       <= '0;
            addr_out_q   <= '0;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            i1_q         <= '0;
            i2_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
`ifdef EX_MEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            en_q    <= 1'b0;
            case (state_q)
                S_IDLE: if (fire) begin
                    if (in_if.in_data == CMD_LOAD)
                        core_reset_q <= 1'b1;
                    else if (in_if.in_data == CMD_RUN)
                        core_reset_q <= 1'b0;
                    else
                        err_q <= 1'b1;
                end
                S_ADDR_HI: if (fire) hi_q <= in_if.in_data;
                S_ADDR_LO: if (fire) addr_q <= ADDR_W'(addr16);
                // COUNT of zero encodes a full 256-entry block.
                S_COUNT:   if (fire) cnt_q <= (in_if.in_data == 8'd0) ? 9'd256 : {1'b0, in_if.in_data};
                S_PAYLOAD: if (pack_full) begin
                    en_q       <= 1'b1;
                    addr_out_q <= addr_q;
                    i1_q       <= w_i1;
                    i2_q       <= w_i2;
                    d1_q       <= w_d1;
                    d2_q       <= w_d2;
                end
                S_WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    cnt_q  <= cnt_q - 9'd1;
                end
`ifdef EX_MEM_LOADER_CHECKSUM_EN
                S_CSUM: if (fire && in_if.in_data != csum_q) err_q <= 1'b1;
`endif
                default: ;
            endcase
`ifdef EX_MEM_LOADER_CHECKSUM_EN
            if (fire && state_q == S_IDLE && in_if.in_data == CMD_LOAD)
                csum_q <= '0;
            else if (fire && (state_q inside {S_ADDR_HI, S_ADDR_LO, S_COUNT, S_PAYLOAD}))
                csum_q <= csum_q ^ in_if.in_data;
`endif
        end
    end

    assign core_reset         = core_reset_q;
    assign enable_load_ex_mem = en_q;
    assign InstExMemAddress   = addr_out_q;
    assign DataExMemAddress   = addr_out_q;
    assign InstExMemData1     = i1_q;
    assign InstExMemData2     = i2_q;
    assign DataExMemData1     = d1_q;
    assign DataExMemData2     = d2_q;
    assign busy               = busy_q;
    assign err                = err_q;

endmodule

// File: tb/tb_ex_mem_loader.sv
// Self-checking bench for ex_mem_loader: random payloads against a frame-level write model.
module tb_ex_mem_loader;

    typedef struct packed {
        logic [8:0]   addr;
        logic [127:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_reset, en, busy, err;
    logic [8:0]  ia, da;
    logic [31:0] i1, i2, d1, d2;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [7:0]  pay_q[$];

    ex_mem_loader_if in_if ();

    ex_mem_loader #(.ADDR_W(9)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_if              (in_if),
        .core_reset         (core_reset),
        .enable_load_ex_mem (en),
        .InstExMemAddress   (ia),
        .DataExMemAddress   (da),
        .InstExMemData1     (i1),
        .InstExMemData2     (i2),
        .DataExMemData1     (d1),
        .DataExMemData2     (d2),
        .busy               (busy),
        .err                (err)
    );

    always #5 clk = ~clk;

    // Capture every write strobe and check the ready/write relationship each cycle.
    always @(negedge clk) begin
        if (!reset && en === 1'b1) begin
            got_q.push_back('{addr: ia, dat: {d2, d1, i2, i1}});
            checks++;
            if (ia !== da) begin
                errors++;
                $display("FAIL addr_match inst=%h data=%h required equal", ia, da);
            end
        end
        if (mon_en && !reset) begin
            checks++;
            if (in_if.in_ready !== !en) begin
                errors++;
                $display("FAIL ready_vs_write in_ready=%b required=%b", in_if.in_ready, !en);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int stall);
        int n;
        while (stall > 0 && int'($urandom_range(99)) < stall) begin
            in_if.in_valid = 1'b0;
            in_if.in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_if.in_valid = 1'b1;
        in_if.in_data  = b;
        n = 0;
        while (in_if.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_if.in_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_if.in_valid = 1'b0;
    endtask

    task automatic fill_random(input int entries);
        pay_q.delete();
        for (int i = 0; i < entries * 16; i++) pay_q.push_back(8'($urandom));
    endtask

    // Reference: entry e goes to (start + e) mod 512; word k is bytes 4k..4k+3, first byte lowest.
    task automatic build_expected(input logic [7:0] hi, input logic [7:0] lo, input int n);
        int  base;
        wr_t w;
        exp_q.delete();
        base = (int'(hi) * 256 + int'(lo)) % 512;
        for (int e = 0; e < n; e++) begin
            w.addr = 9'((base + e) % 512);
            w.dat  = '0;
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 4; j++)
                    w.dat[32*k + 8*j +: 8] = pay_q[16*e + 4*k + j];
            exp_q.push_back(w);
        end
    endtask

    task automatic run_load(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] cnt,
                            input int stall, input bit bad_csum);
        int         n;
        logic [7:0] x;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        got_q.delete();
        build_expected(hi, lo, n);
        send_byte(8'hA5, stall);
        send_byte(hi, stall);
        send_byte(lo, stall);
        send_byte(cnt, stall);
        x = hi ^ lo ^ cnt;
        for (int i = 0; i < n * 16; i++) begin
            send_byte(pay_q[i], stall);
            x = x ^ pay_q[i];
        end
`ifdef EX_MEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~x : x, stall);
`else
        if (bad_csum) x = ~x;
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        checks += 7;
        if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_if.in_ready); end
        if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (en !== 1'b0) begin errors++; $display("FAIL rst_enable got=%b exp=0", en); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        if ({ia, da} !== 18'd0) begin errors++; $display("FAIL rst_addr got=%h/%h exp=0", ia, da); end
        if ({i1, i2, d1, d2} !== 128'd0) begin errors++; $display("FAIL rst_data got=%h %h %h %h exp=0", i1, i2, d1, d2); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", in_if.in_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] words [4];
        words[0] = 32'h00100393; words[1] = 32'h00038303;
        words[2] = 32'h00008F00; words[3] = 32'h000000FF;
        pay_q.delete();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) pay_q.push_back(8'(words[k] >> (8*j)));
        run_load(8'h00, 8'h00, 8'h01, 0, 1'b0);
        checks += 4;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL basic_pulses got=%0d exp=1", got_q.size());
        end else begin
            if (got_q[0].addr !== 9'd0) begin errors++; $display("FAIL basic_addr got=%0d exp=0", got_q[0].addr); end
            if (got_q[0].dat !== {32'h000000FF, 32'h00008F00, 32'h00038303, 32'h00100393}) begin
                errors++; $display("FAIL basic_data got=%h exp=000000ff00008f000003830300100393", got_q[0].dat);
            end
        end
        if (core_reset !== 1'b1) begin errors++; $display("FAIL basic_core_reset_held got=%b exp=1", core_reset); end
        send_byte(8'h3C, 0);
        checks += 2;
        if (core_reset !== 1'b0) begin errors++; $display("FAIL run_release got=%b exp=0", core_reset); end
        if (busy !== 1'b0) begin errors++; $display("FAIL run_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wrap;
        fill_random(2);
        run_load(8'hFF, 8'hFF, 8'h02, 0, 1'b0);
        checks += 3;
        if (core_reset !== 1'b1) begin errors++; $display("FAIL load_reasserts got=%b exp=1", core_reset); end
        if (got_q.size() != 2) begin errors++; $display("FAIL wrap_pulses got=%0d exp=2", got_q.size()); end
        if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b exp=0", err); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap_entry%0d got=%h:%h exp=%h:%h", i, got_q[i].addr, got_q[i].dat, exp_q[i].addr, exp_q[i].dat);
            end
        end
    endtask

    task automatic test_stall;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) fill_random(3);
            run_load(8'h00, 8'h40, 8'h03, pass * 50, 1'b0);
            checks++;
            if (got_q.size() != 3) begin errors++; $display("FAIL stall%0d_pulses got=%0d exp=3", pass, got_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stall%0d_entry%0d got=%h:%h exp=%h:%h", pass, i, got_q[i].addr, got_q[i].dat, exp_q[i].addr, exp_q[i].dat);
                end
            end
        end
    endtask

    task automatic test_bad_cmd;
        send_byte(8'h77, 0);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL badcmd_err got=%b exp=1", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy got=%b exp=0", busy); end
        fill_random(1);
        run_load(8'h00, 8'h05, 8'h01, 0, 1'b0);
        checks += 2;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL badcmd_load pulses=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
        if (err !== 1'b1) begin errors++; $display("FAIL badcmd_sticky got=%b exp=1", err); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL badcmd_cleared got=%b exp=0", err); end
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 0);
        reset = 1'b1;
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", in_if.in_ready); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL mid_no_pulse got=%0d exp=0", got_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b exp=0", busy); end
        fill_random(1);
        run_load(8'h00, 8'h11, 8'h01, 0, 1'b0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL mid_reload pulses=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_count256;
        fill_random(256);
        run_load(8'h01, 8'h80, 8'h00, 0, 1'b0);
        checks++;
        if (got_q.size() != 256) begin errors++; $display("FAIL c256_pulses got=%0d exp=256", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL c256_entry%0d got=%h:%h exp=%h:%h", i, got_q[i].addr, got_q[i].dat, exp_q[i].addr, exp_q[i].dat);
            end
        end
    endtask

`ifdef EX_MEM_LOADER_CHECKSUM_EN
    task automatic test_csum;
        fill_random(2);
        run_load(8'h00, 8'h20, 8'h02, 0, 1'b0);
        checks += 2;
        if (err !== 1'b0) begin errors++; $display("FAIL csum_good_err got=%b exp=0", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL csum_good_idle got=%b exp=0", busy); end
        run_load(8'h00, 8'h20, 8'h02, 0, 1'b1);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL csum_bad_err got=%b exp=1", err); end
        if (got_q.size() != 2) begin errors++; $display("FAIL csum_bad_writes got=%0d exp=2", got_q.size()); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_stall;
        test_bad_cmd;
        test_reset_mid;
        test_count256;
`ifdef EX_MEM_LOADER_CHECKSUM_EN
        test_csum;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
